vc_input_buffer: RTL and testbench

Per-input-port flit buffer that sits directly downstream of `input_router`. It accepts each 32-bit flit together with the `vc_select` output-direction code the router computed for it, and enqueues the flit into one of five per-direction FIFOs (virtual channels). Each FIFO exposes its head flit to the switch allocator and crossbar through a valid/ready handshake. Flits leave each queue in order, and the queues are fully independent.

---
 rtl/vc_input_buffer_if.sv | 28 ++
 rtl/vc_input_buffer.sv | 96 +++++++++
 tb/tb_vc_input_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vc_input_buffer_if.sv
// Handshake bundle between input_router and a vc_input_buffer, plus the
// per-VC head-of-queue outputs facing the switch allocator and crossbar.
interface vc_input_buffer_if #(
  parameter int DSIZE = 32,
  parameter int NVC   = 5
);
  logic                 in_valid;
  logic [DSIZE-1:0]     data_in;
  logic [2:0]           vc_select;
  logic                 in_ready;
  logic [NVC-1:0]       out_valid;
  logic [NVC*DSIZE-1:0] out_data;
  logic [NVC-1:0]       out_ready;
  logic [NVC-1:0]       vc_full;
  logic                 drop_err;

  // Upstream router / downstream allocator side.
  modport master (
    output in_valid, data_in, vc_select, out_ready,
    input  in_ready, out_valid, out_data, vc_full, drop_err
  );

  // Buffer side.
  modport slave (
    input  in_valid, data_in, vc_select, out_ready,
    output in_ready, out_valid, out_data, vc_full, drop_err
  );
endinterface

// File: rtl/vc_input_buffer.sv
// Per-input-port flit buffer: five independent per-direction FIFOs (L,N,E,S,W)
// fed by one write port, each with its own valid/ready head-of-queue output.
module vc_input_buffer #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 4,
  parameter int NVC   = 5
) (
  input  logic                clk,
  input  logic                reset,
  vc_input_buffer_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  logic [NVC-1:0]       wr_en;
  logic [NVC-1:0]       rd_en;
  logic [NVC-1:0]       valid_vec;
  logic [NVC-1:0]       full_vec;
  logic [NVC*DSIZE-1:0] data_vec;
  logic                 sel_legal;
  logic                 in_ready_next;
  logic                 drop_err_reg;

  assign sel_legal = (bus.vc_select < 3'(NVC));

  // Readiness depends only on the selected queue's full flag, so a read in
  // the same cycle never opens room for a write into a full queue.
  always_comb begin
    in_ready_next = 1'b1;
    for (int i = 0; i < NVC; i++) begin
      if (bus.vc_select == 3'(i)) begin
        in_ready_next = !full_vec[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NVC; gi++) begin : g_vc
      logic [DSIZE-1:0] mem_reg [DEPTH];
      logic [AW-1:0]    wp_reg;
      logic [AW-1:0]    rp_reg;
      logic [AW:0]      cnt_reg;

      assign wr_en[gi] = bus.in_valid && sel_legal &&
                         (bus.vc_select == 3'(gi)) && !full_vec[gi];
      assign rd_en[gi] = valid_vec[gi] && bus.out_ready[gi];

      assign valid_vec[gi] = (cnt_reg != '0);
      assign full_vec[gi]  = (cnt_reg == (AW+1)'(DEPTH));
      assign data_vec[gi*DSIZE +: DSIZE] = mem_reg[rp_reg];

      always_ff @(posedge clk) begin
        if (reset) begin
          wp_reg  <= '0;
          rp_reg  <= '0;
          cnt_reg <= '0;
        end else begin
          if (wr_en[gi]) begin
            wp_reg <= wp_reg + 1'b1;
          end
          if (rd_en[gi]) begin
            rp_reg <= rp_reg + 1'b1;
          end
          case ({wr_en[gi], rd_en[gi]})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end

      // Storage is deliberately left out of reset; the reset guard only keeps
      // a handshake in the reset cycle from touching it.
      always_ff @(posedge clk) begin
        if (!reset && wr_en[gi]) begin
          mem_reg[wp_reg] <= bus.data_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err_reg <= 1'b0;
    end else begin
      drop_err_reg <= bus.in_valid && !sel_legal;
    end
  end

  assign bus.in_ready  = in_ready_next;
  assign bus.out_valid = valid_vec;
  assign bus.vc_full   = full_vec;
  assign bus.out_data  = data_vec;
  assign bus.drop_err  = drop_err_reg;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer: single write, fill/refuse/drain,
// full-with-read refusal, streaming across pointer wrap, illegal drop, reset.
module tb_vc_input_buffer;
  localparam int DSIZE = 32;
  localparam int DEPTH = 4;
  localparam int NVC   = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vc_input_buffer_if #(.DSIZE(DSIZE), .NVC(NVC)) bus ();

  vc_input_buffer #(.DSIZE(DSIZE), .DEPTH(DEPTH), .NVC(NVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DSIZE-1:0] head(input int q);
    return bus.out_data[q*DSIZE +: DSIZE];
  endfunction

  task automatic write(input logic [2:0] vc, input logic [DSIZE-1:0] d);
    bus.in_valid  = 1'b1;
    bus.vc_select = vc;
    bus.data_in   = d;
    tick();
    bus.in_valid  = 1'b0;
    $display("write vc=%0d data=%h", vc, d);
  endtask

  initial begin
    logic [DSIZE-1:0] exp_n [4];
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.vc_select = 3'd0;
    bus.out_ready = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_vc_full",   64'(bus.vc_full),   64'h0);
    chk("rst_drop_err",  64'(bus.drop_err),  64'h0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'h1);

    // Single flit to E, then dequeue.
    write(3'd2, 32'h0201BBBB);
    chk("e_out_valid", 64'(bus.out_valid), 64'h04);
    chk("e_head",      64'(head(2)),       64'h0201BBBB);
    bus.out_ready = 5'b00100;
    tick();
    bus.out_ready = '0;
    $display("read vc=2");
    chk("e_drained", 64'(bus.out_valid), 64'h0);

    // Fill N.
    for (int k = 0; k < 4; k++) write(3'd1, 32'hA0 + 32'(k));
    bus.vc_select = 3'd1;
    #1;
    chk("n_full",        64'(bus.vc_full),  64'h02);
    chk("n_in_ready_lo", 64'(bus.in_ready), 64'h0);
    write(3'd1, 32'hA4);
    chk("n_refused_full", 64'(bus.vc_full), 64'h02);
    chk("n_head_a0",      64'(head(1)),     64'hA0);

    // Full queue read together with a write: the write must be refused.
    bus.out_ready = 5'b00010;
    bus.in_valid  = 1'b1;
    bus.vc_select = 3'd1;
    bus.data_in   = 32'hA5;
    #1;
    chk("n_rw_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    $display("read vc=1 with refused write data=000000a5");
    chk("n_rw_not_full", 64'(bus.vc_full), 64'h00);
    chk("n_rw_head_a1",  64'(head(1)),     64'hA1);
    bus.in_valid = 1'b1;
    bus.data_in  = 32'hA6;
    #1;
    chk("n_cnt3_in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_valid = 1'b0;
    $display("write vc=1 data=000000a6");
    chk("n_refull", 64'(bus.vc_full), 64'h02);

    exp_n[0] = 32'hA1; exp_n[1] = 32'hA2; exp_n[2] = 32'hA3; exp_n[3] = 32'hA6;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("n_drain_valid%0d", k), 64'(bus.out_valid[1]), 64'h1);
      chk($sformatf("n_drain_data%0d", k),  64'(head(1)),          64'(exp_n[k]));
      bus.out_ready = 5'b00010;
      tick();
      bus.out_ready = '0;
      $display("read vc=1 data=%h", exp_n[k]);
    end
    chk("n_empty", 64'(bus.out_valid), 64'h0);

    // Streaming through S with a permanently ready consumer.
    bus.out_ready = 5'b01000;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid  = 1'b1;
      bus.vc_select = 3'd3;
      bus.data_in   = 32'h5500_0000 + 32'(k);
      tick();
      $display("stream vc=3 data=%h", 32'h5500_0000 + 32'(k));
      chk($sformatf("s_valid%0d", k), 64'(bus.out_valid), 64'h08);
      chk($sformatf("s_data%0d", k),  64'(head(3)),       64'h5500_0000 + 64'(k));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = '0;
    chk("s_empty", 64'(bus.out_valid), 64'h0);

    // Illegal select is consumed and flagged without touching queues.
    write(3'd0, 32'h0000_0011);
    bus.in_valid  = 1'b1;
    bus.vc_select = 3'd6;
    bus.data_in   = 32'hDEAD_0006;
    #1;
    chk("ill_in_ready", 64'(bus.in_ready), 64'h1);
    chk("ill_no_early", 64'(bus.drop_err), 64'h0);
    tick();
    bus.in_valid = 1'b0;
    $display("write vc=6 data=dead0006 (illegal)");
    chk("ill_drop_err",  64'(bus.drop_err),  64'h1);
    chk("ill_out_valid", 64'(bus.out_valid), 64'h01);
    chk("ill_vc_full",   64'(bus.vc_full),   64'h00);
    tick();
    chk("ill_drop_clr", 64'(bus.drop_err), 64'h0);

    // Load L, N, W with two flits each, then reset mid-operation.
    write(3'd0, 32'h0000_0012);
    write(3'd1, 32'h0000_0021);
    write(3'd1, 32'h0000_0022);
    write(3'd4, 32'h0000_0041);
    write(3'd4, 32'h0000_0042);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'h13);
    chk("pre_rst_head_w", 64'(head(4)),      64'h41);
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.vc_select = 3'd4;
    bus.data_in   = 32'hBAD0_0004;
    bus.out_ready = 5'b11111;
    tick();
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    $display("reset with write vc=4 data=bad00004");
    chk("mid_rst_valid",    64'(bus.out_valid), 64'h0);
    chk("mid_rst_full",     64'(bus.vc_full),   64'h0);
    chk("mid_rst_in_ready", 64'(bus.in_ready),  64'h1);
    write(3'd4, 32'h4444_0004);
    chk("post_rst_valid", 64'(bus.out_valid), 64'h10);
    chk("post_rst_head",  64'(head(4)),       64'h4444_0004);
    bus.out_ready = 5'b10000;
    tick();
    bus.out_ready = '0;
    $display("read vc=4");
    chk("post_rst_empty", 64'(bus.out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
